// File: rtl/wb_arbiter.sv
// wb_arbiter -- writeback arbiter for the CPU core.
//
// Collects results from three execution sources (ALU, MDU, LSU) into one
// holding slot each and serialises them onto the single register-file write
// port, one registered write per cycle.
//   - Same-destination results retire in acceptance order (age matrix).
//   - A slot that has waited STARVE_LIMIT cycles jumps the LSU > MDU > ALU
//     fixed priority, so no eligible entry waits longer than STARVE_LIMIT+2.
//   - rd == 0 results are accepted and dropped.
//
// Ports
//   clk, reset                 core clock; synchronous active-low reset
//   {alu,mdu,lsu}_valid/_ready source handshake (ready independent of valid)
//   {alu,mdu,lsu}_rd/_data     destination register / result value
//   regWriteEn, rd_out,
//   regWriteData               registered register-file write port
//   byp_r{j,k}_in/_hit/_data   bypass lookup of results still held in slots
//
// Optional feature: define WB_BYPASS_EN to build the bypass compare logic;
// otherwise the bypass outputs are tied to zero.

module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        regWriteEn,
  output logic [4:0]  rd_out,
  output logic [31:0] regWriteData,
  input  logic [4:0]  byp_rj_in,
  input  logic [4:0]  byp_rk_in,
  output logic        byp_rj_hit,
  output logic        byp_rk_hit,
  output logic [31:0] byp_rj_data,
  output logic [31:0] byp_rk_data
);
  // Slot index: 0 = ALU, 1 = MDU, 2 = LSU (higher index = higher fixed priority)
  localparam int NSRC = 3;
  localparam int GW   = 5;
  localparam int DW   = 32;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [NSRC-1:0]          in_vld;
  logic [NSRC-1:0][GW-1:0]  in_rd;
  logic [NSRC-1:0][DW-1:0]  in_data;

  assign in_vld  = {lsu_valid, mdu_valid, alu_valid};
  assign in_rd   = {lsu_rd,    mdu_rd,    alu_rd};
  assign in_data = {lsu_data,  mdu_data,  alu_data};

  logic [NSRC-1:0]            vld_q,   vld_d;
  logic [NSRC-1:0][GW-1:0]    rd_q,    rd_d;
  logic [NSRC-1:0][DW-1:0]    data_q,  data_d;
  logic [NSRC-1:0][3:0]       cnt_q,   cnt_d;
  // older_q[i][j]: slot i was accepted before slot j (meaningful only when both occupied)
  logic [NSRC-1:0][NSRC-1:0]  older_q, older_d;

  logic          regWriteEn_q;
  logic [GW-1:0] rd_out_q;
  logic [DW-1:0] wdata_q;

  logic [NSRC-1:0] rdy, load, blocked, elig, starved, cand, gnt;
  logic [GW-1:0]   gnt_rd;
  logic [DW-1:0]   gnt_data;

  // ---------------------------------------------------------------------------
  // Eligibility: hold back a slot while an older occupied slot targets the same rd
  // ---------------------------------------------------------------------------
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NSRC; i++)
      for (int j = 0; j < NSRC; j++)
        if (j != i && vld_q[j] && older_q[j][i] && rd_q[j] == rd_q[i])
          blocked[i] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Grant: starved slots first, then LSU > MDU > ALU within the chosen set
  // ---------------------------------------------------------------------------
  always_comb begin
    elig    = vld_q & ~blocked;
    starved = '0;
    for (int i = 0; i < NSRC; i++)
      starved[i] = elig[i] && (cnt_q[i] == LIMIT);
    cand = (|starved) ? starved : elig;
    gnt  = '0;
    if      (cand[2]) gnt = 3'b100;
    else if (cand[1]) gnt = 3'b010;
    else if (cand[0]) gnt = 3'b001;
    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < NSRC; i++)
      if (gnt[i]) begin
        gnt_rd   = rd_q[i];
        gnt_data = data_q[i];
      end
  end

  // A slot can take a new entry when empty or when it drains this cycle.
  assign rdy = {NSRC{reset}} & (~vld_q | gnt);

  always_comb begin
    load = '0;
    for (int i = 0; i < NSRC; i++)
      load[i] = in_vld[i] && rdy[i] && (in_rd[i] != '0);
  end

  assign alu_ready = rdy[0];
  assign mdu_ready = rdy[1];
  assign lsu_ready = rdy[2];

  // ---------------------------------------------------------------------------
  // Slot next state
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_d   = vld_q;
    rd_d    = rd_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    older_d = older_q;
    for (int i = 0; i < NSRC; i++) begin
      if (load[i]) begin
        // load wins over grant: a drained slot refilled the same cycle is youngest
        vld_d[i]  = 1'b1;
        rd_d[i]   = in_rd[i];
        data_d[i] = in_data[i];
        cnt_d[i]  = '0;
      end else if (gnt[i]) begin
        vld_d[i] = 1'b0;
        cnt_d[i] = '0;
      end else if (vld_q[i] && cnt_q[i] != LIMIT) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
    // New entries become younger than everything; simultaneous arrivals rank
    // by slot index (ALU oldest).
    for (int j = 0; j < NSRC; j++)
      if (load[j])
        for (int i = 0; i < NSRC; i++)
          if (i != j) begin
            if (load[i]) begin
              older_d[i][j] = (i < j);
            end else begin
              older_d[i][j] = 1'b1;
              older_d[j][i] = 1'b0;
            end
          end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q        <= '0;
      rd_q         <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      older_q      <= '0;
      regWriteEn_q <= 1'b0;
      rd_out_q     <= '0;
      wdata_q      <= '0;
    end else begin
      vld_q        <= vld_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      older_q      <= older_d;
      regWriteEn_q <= |gnt;
      if (|gnt) begin
        rd_out_q <= gnt_rd;
        wdata_q  <= gnt_data;
      end
    end
  end

  assign regWriteEn   = regWriteEn_q;
  assign rd_out       = rd_out_q;
  assign regWriteData = wdata_q;

  // ---------------------------------------------------------------------------
  // Bypass lookup over held slots (output register is covered by the regfile)
  // ---------------------------------------------------------------------------
`ifdef WB_BYPASS_EN
  logic [1:0][GW-1:0]   byp_addr;
  logic [1:0]           byp_hit;
  logic [1:0][DW-1:0]   byp_data;
  logic [1:0][NSRC-1:0] byp_match;
  logic [1:0][NSRC-1:0] byp_has_younger;

  assign byp_addr = {byp_rk_in, byp_rj_in};

  always_comb begin
    byp_hit         = '0;
    byp_data        = '0;
    byp_match       = '0;
    byp_has_younger = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NSRC; i++)
        byp_match[p][i] = vld_q[i] && (byp_addr[p] != '0) && (rd_q[i] == byp_addr[p]);
      for (int i = 0; i < NSRC; i++) begin
        for (int j = 0; j < NSRC; j++)
          if (j != i && byp_match[p][j] && older_q[i][j])
            byp_has_younger[p][i] = 1'b1;
        if (byp_match[p][i] && !byp_has_younger[p][i])
          byp_data[p] = data_q[i];
      end
      byp_hit[p] = |byp_match[p];
    end
  end

  assign byp_rj_hit  = byp_hit[0];
  assign byp_rk_hit  = byp_hit[1];
  assign byp_rj_data = byp_data[0];
  assign byp_rk_data = byp_data[1];
`else
  logic unused_byp;
  assign unused_byp  = ^{byp_rj_in, byp_rk_in};
  assign byp_rj_hit  = 1'b0;
  assign byp_rk_hit  = 1'b0;
  assign byp_rj_data = '0;
  assign byp_rk_data = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected register writes
// (rd, data, allowed cycle window); a negedge monitor pops and compares every
// regWriteEn pulse. Direct checks cover reset, ready and bypass values.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mdu_valid, lsu_valid;
  logic        alu_ready, mdu_ready, lsu_ready;
  logic [4:0]  alu_rd, mdu_rd, lsu_rd;
  logic [31:0] alu_data, mdu_data, lsu_data;
  logic        regWriteEn;
  logic [4:0]  rd_out;
  logic [31:0] regWriteData;
  logic [4:0]  byp_rj_in, byp_rk_in;
  logic        byp_rj_hit, byp_rk_hit;
  logic [31:0] byp_rj_data, byp_rk_data;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .regWriteEn(regWriteEn), .rd_out(rd_out), .regWriteData(regWriteData),
    .byp_rj_in(byp_rj_in), .byp_rk_in(byp_rk_in),
    .byp_rj_hit(byp_rj_hit), .byp_rk_hit(byp_rk_hit),
    .byp_rj_data(byp_rj_data), .byp_rk_data(byp_rk_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of posedges seen
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          lo;
    int          hi;
  } wr_t;
  wr_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic void expect_wr(input logic [4:0] rd, input logic [31:0] data,
                                    input int lo, input int hi);
    wr_t e;
    e.rd = rd; e.data = data; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endfunction

  // Monitor: every write-port pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (regWriteEn === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%h at cycle %0d, expected no write",
                 rd_out, regWriteData, cyc);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (rd_out !== e.rd || regWriteData !== e.data || cyc < e.lo || cyc > e.hi) begin
          errors++;
          $display("FAIL wb_write: got rd=%0d data=0x%h cycle %0d, expected rd=%0d data=0x%h cycle %0d..%0d",
                   rd_out, regWriteData, cyc, e.rd, e.data, e.lo, e.hi);
        end
      end
    end
  end

  task automatic idle();
    alu_valid = 1'b0; mdu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_ready(input string name, input logic a, input logic m, input logic l);
    check({name, "_alu_ready"}, alu_ready, a);
    check({name, "_mdu_ready"}, mdu_ready, m);
    check({name, "_lsu_ready"}, lsu_ready, l);
  endtask

  int c;

  initial begin
    // Reset held 2 cycles with all valids high
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAAAA_0001;
    mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_data = 32'hAAAA_0002;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hAAAA_0003;
    byp_rj_in = 5'd0; byp_rk_in = 5'd0;
    repeat (2) begin
      @(negedge clk);
      check("rst_we", regWriteEn, 32'd0);
      check("rst_rd", rd_out, 32'd0);
      check("rst_data", regWriteData, 32'd0);
      check_ready("rst", 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    idle();
    @(negedge clk);
    check_ready("post_rst", 1'b1, 1'b1, 1'b1);
    wait_cyc(3);

    // Three sources at the same edge: LSU, MDU, ALU on consecutive cycles
    c = cyc;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h22;
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'h33;
    expect_wr(5'd5, 32'h33, c + 2, c + 2);
    expect_wr(5'd4, 32'h22, c + 3, c + 3);
    expect_wr(5'd3, 32'h11, c + 4, c + 4);
    @(negedge clk);
    idle();
    check_ready("three", 1'b0, 1'b0, 1'b1);
    wait_cyc(5);

    // Same rd from ALU and LSU: older ALU result first; bypass sees the younger one
    c = cyc;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hB;
    expect_wr(5'd7, 32'hA, c + 2, c + 2);
    expect_wr(5'd7, 32'hB, c + 3, c + 3);
    @(negedge clk);
    idle();
    byp_rj_in = 5'd7; byp_rk_in = 5'd0;
    #1;
`ifdef WB_BYPASS_EN
    check("byp7_hit", byp_rj_hit, 32'd1);
    check("byp7_data", byp_rj_data, 32'hB);
`else
    check("byp7_hit", byp_rj_hit, 32'd0);
    check("byp7_data", byp_rj_data, 32'd0);
`endif
    check("byp0_hit", byp_rk_hit, 32'd0);
    check("byp0_data", byp_rk_data, 32'd0);
    byp_rj_in = 5'd0;
    wait_cyc(4);

    // Starvation: ALU rd=9 held while LSU streams a new rd every cycle
    c = cyc;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int k = 0; k < 5; k++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(10 + k); lsu_data = 32'h100 + 32'(k);
      if (k == 4) begin
        expect_wr(5'd9, 32'h99, c + 2, c + 7);
        expect_wr(5'd14, 32'h104, c + 7, c + 7);
      end else begin
        expect_wr(5'(10 + k), 32'h100 + 32'(k), c + k + 2, c + k + 2);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      if (k < 4) check("stream_lsu_ready", lsu_ready, 32'd1);
    end
    check("starve_lsu_ready", lsu_ready, 32'd0);
    check("starve_alu_ready", alu_ready, 32'd1);
    lsu_valid = 1'b0;
    wait_cyc(5);

    // rd == 0 is dropped; next ALU result follows with the normal latency
    c = cyc;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rd0_alu_ready", alu_ready, 32'd1);
    alu_rd = 5'd1; alu_data = 32'h1;
    expect_wr(5'd1, 32'h1, c + 3, c + 3);
    @(negedge clk);
    idle();
    wait_cyc(4);

    // Reset right after three entries are accepted: nothing is written
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
    mdu_valid = 1'b1; mdu_rd = 5'd21; mdu_data = 32'h2121;
    lsu_valid = 1'b1; lsu_rd = 5'd22; lsu_data = 32'h2222;
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    check_ready("mid_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_rst_we", regWriteEn, 32'd0);
    check("mid_rst_rd", rd_out, 32'd0);
    check("mid_rst_data", regWriteData, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_ready("after_mid_rst", 1'b1, 1'b1, 1'b1);
    wait_cyc(4);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
